exec_issue_sched: RTL and testbench

//  Round-robin issue scheduler in front of the execute stage. Shares the execute units among NSTREAM instruction streams.
//  - Picks at most one ready stream per cycle and drives the registered issue controls: xu_sel and tag_in.
//  - Blocks memory ops while the memory unit is occupied.
//  - Squashes a stream's requests for FLUSH_CYC cycles after a taken jump on that stream.

---
 rtl/my_pkg.sv | 16 +
 rtl/exec_issue_sched_if.sv | 25 ++
 rtl/exec_issue_sched_rr_pick.sv | 33 +++
 rtl/exec_issue_sched.sv | 120 ++++++++++++
 tb/tb_exec_issue_sched.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/my_pkg.sv
// Shared execute-stage definitions: execution unit select and stream tag types.
package my_pkg;

    typedef enum logic [1:0] {
        XU_BYPASS  = 2'd0,
        XU_ADDER   = 2'd1,
        XU_LOGICAL = 2'd2,
        XU_MEMORY  = 2'd3
    } xu;

    localparam int STREAM_TAG_W     = 4;
    localparam int EXEC_NSTREAM_MAX = 16;

    typedef logic [STREAM_TAG_W-1:0] stream_tag_t;

endpackage

// File: rtl/exec_issue_sched_if.sv
// Request/grant and issue bundle between operand fetch, the issue scheduler and execute.
interface exec_issue_sched_if
    import my_pkg::*;
#(
    parameter int NSTREAM = 4
) ();

    logic [NSTREAM-1:0] req_valid;
    xu    [NSTREAM-1:0] req_xu;
    logic [NSTREAM-1:0] req_gnt;
    logic               issue_valid;
    xu                  issue_xu;
    stream_tag_t        issue_tag;

    modport master (
        output req_valid, req_xu,
        input  req_gnt, issue_valid, issue_xu, issue_tag
    );

    modport slave (
        input  req_valid, req_xu,
        output req_gnt, issue_valid, issue_xu, issue_tag
    );

endinterface

// File: rtl/exec_issue_sched_rr_pick.sv
// Combinational rotating-priority picker: the first eligible stream after ptr wins.
module exec_issue_sched_rr_pick
    import my_pkg::*;
#(
    parameter int NSTREAM = 4
) (
    input  logic [NSTREAM-1:0] elig,
    input  stream_tag_t        ptr,
    output logic [NSTREAM-1:0] gnt,
    output stream_tag_t        idx,
    output logic               any
);

    int cand;

    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int k = 1; k <= NSTREAM; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NSTREAM) cand = cand - NSTREAM;
            if (!any && elig[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = stream_tag_t'(cand);
            end
        end
    end

endmodule

// File: rtl/exec_issue_sched.sv
// Round-robin issue scheduler sharing the execute units among NSTREAM streams.
// Optional performance counters are enabled with `define EXEC_SCHED_PERF_EN.
module exec_issue_sched
    import my_pkg::*;
#(
    parameter int NSTREAM      = 4,
    parameter int MEM_BUSY_CYC = 2,
    parameter int FLUSH_CYC    = 2
) (
    input  logic                clk,
    input  logic                reset,
    exec_issue_sched_if.slave   bus,
    input  logic                stall_in,
    input  logic                jump_in,
    input  stream_tag_t         jump_tag,
    output logic                busy_mem
`ifdef EXEC_SCHED_PERF_EN
    ,
    output logic [31:0]         grant_cnt [NSTREAM],
    output logic [31:0]         blk_cnt
`endif
);

    localparam int MEM_W   = $clog2(MEM_BUSY_CYC + 1);
    localparam int FLUSH_W = $clog2(FLUSH_CYC + 1);
    localparam logic [MEM_W-1:0]   MEM_LOAD   = MEM_W'(MEM_BUSY_CYC);
    localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYC);

    logic [MEM_W-1:0]   mem_cnt;
    logic [FLUSH_W-1:0] flush_cnt [NSTREAM];
    stream_tag_t        rr_ptr;
    logic [NSTREAM-1:0] elig;
    logic [NSTREAM-1:0] gnt;
    stream_tag_t        gnt_idx;
    logic               gnt_any;
    xu                  gnt_xu;

    // Gating with reset keeps operand fetch from popping while the scheduler is held.
    always_comb begin
        elig   = '0;
        gnt_xu = XU_BYPASS;
        for (int s = 0; s < NSTREAM; s++) begin
            elig[s] = reset && bus.req_valid[s] && (flush_cnt[s] == '0) && !stall_in
                      && !(bus.req_xu[s] == XU_MEMORY && mem_cnt != '0)
                      && !(jump_in && jump_tag == stream_tag_t'(s));
            if (gnt[s]) gnt_xu = bus.req_xu[s];
        end
    end

    exec_issue_sched_rr_pick #(
        .NSTREAM (NSTREAM)
    ) u_rr_pick (
        .elig (elig),
        .ptr  (rr_ptr),
        .gnt  (gnt),
        .idx  (gnt_idx),
        .any  (gnt_any)
    );

    assign bus.req_gnt = gnt;
    assign busy_mem    = (mem_cnt != '0);

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr          <= stream_tag_t'(NSTREAM - 1);
            bus.issue_valid <= 1'b0;
            bus.issue_xu    <= XU_BYPASS;
            bus.issue_tag   <= '0;
            mem_cnt         <= '0;
        end else begin
            if (gnt_any) begin
                rr_ptr          <= gnt_idx;
                bus.issue_valid <= 1'b1;
                bus.issue_xu    <= gnt_xu;
                bus.issue_tag   <= gnt_idx;
            end else begin
                bus.issue_valid <= 1'b0;
                bus.issue_xu    <= XU_BYPASS;
                bus.issue_tag   <= '0;
            end
            if (gnt_any && gnt_xu == XU_MEMORY) begin
                mem_cnt <= MEM_LOAD;
            end else if (mem_cnt != '0) begin
                mem_cnt <= mem_cnt - MEM_W'(1);
            end
        end
    end

    // A jump tag outside the stream range matches no counter and is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the flush counters are a handful of flops, so each is reset explicitly.
            for (int s = 0; s < NSTREAM; s++) flush_cnt[s] <= '0;
        end else begin
            for (int s = 0; s < NSTREAM; s++) begin
                if (jump_in && jump_tag == stream_tag_t'(s)) begin
                    flush_cnt[s] <= FLUSH_LOAD;
                end else if (flush_cnt[s] != '0) begin
                    flush_cnt[s] <= flush_cnt[s] - FLUSH_W'(1);
                end
            end
        end
    end

`ifdef EXEC_SCHED_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NSTREAM; s++) grant_cnt[s] <= '0;
            blk_cnt <= '0;
        end else begin
            for (int s = 0; s < NSTREAM; s++) begin
                if (gnt[s]) grant_cnt[s] <= grant_cnt[s] + 32'd1;
            end
            if ((|bus.req_valid) && !gnt_any) blk_cnt <= blk_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_exec_issue_sched.sv
// Self-checking bench for exec_issue_sched against a timestamp-based scheduling model.
module tb_exec_issue_sched;
    import my_pkg::*;

    localparam int N  = 4;
    localparam int MB = 2;
    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_in;
    logic        jump_in;
    stream_tag_t jump_tag;
    logic        busy_mem;
`ifdef EXEC_SCHED_PERF_EN
    logic [31:0] grant_cnt [N];
    logic [31:0] blk_cnt;
`endif

    exec_issue_sched_if #(.NSTREAM(N)) bus ();

    exec_issue_sched #(
        .NSTREAM      (N),
        .MEM_BUSY_CYC (MB),
        .FLUSH_CYC    (FC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .stall_in  (stall_in),
        .jump_in   (jump_in),
        .jump_tag  (jump_tag),
        .busy_mem  (busy_mem)
`ifdef EXEC_SCHED_PERF_EN
        ,
        .grant_cnt (grant_cnt),
        .blk_cnt   (blk_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Model: cycle timestamps of the last memory grant, last jump per stream and last granted stream.
    int          cyc;
    int          last_g;
    int          last_mem;
    int          last_jump [N];
    int          m_grants  [N];
    int          m_blk;
    logic        ev;
    xu           exu;
    stream_tag_t etag;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [N-1:0] exp_g;

    function automatic logic model_busy();
        return (cyc - last_mem >= 1) && (cyc - last_mem <= MB);
    endfunction

    function automatic logic [N-1:0] model_gnt();
        int  s;
        logic ok;
        for (int k = 1; k <= N; k++) begin
            s  = (last_g + k) % N;
            ok = bus.req_valid[s] && !stall_in
                 && !(jump_in && int'(jump_tag) == s)
                 && !((cyc - last_jump[s] >= 1) && (cyc - last_jump[s] <= FC))
                 && !(bus.req_xu[s] == XU_MEMORY && model_busy());
            if (ok) return N'(1) << s;
        end
        return '0;
    endfunction

    task automatic model_reset();
        cyc = 0; last_g = N - 1; last_mem = -100; m_blk = 0;
        for (int s = 0; s < N; s++) begin last_jump[s] = -100; m_grants[s] = 0; end
        ev = 1'b0; exu = XU_BYPASS; etag = '0;
    endtask

    task automatic tick(input logic [N-1:0] g);
        @(posedge clk);
        ev = 1'b0; exu = XU_BYPASS; etag = '0;
        for (int s = 0; s < N; s++) begin
            if (g[s]) begin
                ev = 1'b1; exu = bus.req_xu[s]; etag = stream_tag_t'(s);
                last_g = s; m_grants[s]++;
                if (bus.req_xu[s] == XU_MEMORY) last_mem = cyc;
            end
        end
        if ((|bus.req_valid) && g == '0) m_blk++;
        if (jump_in && int'(jump_tag) < N) last_jump[jump_tag] = cyc;
        cyc++;
        #1;
    endtask

    task automatic drive(input logic [N-1:0] v, input xu x);
        bus.req_valid = v;
        for (int s = 0; s < N; s++) bus.req_xu[s] = x;
    endtask

    task automatic do_reset();
        reset = 1'b0; stall_in = 1'b0; jump_in = 1'b0; jump_tag = '0;
        drive('0, XU_ADDER);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b0; stall_in = 1'b0; jump_in = 1'b0; jump_tag = '0;
        drive('1, XU_MEMORY);
        #3;
        n_checks++;
        if (bus.issue_valid !== 1'b0 || bus.issue_xu !== XU_BYPASS || bus.issue_tag !== 4'd0 || busy_mem !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: got v=%b xu=%0d tag=%0d busy=%b want 0/0/0/0",
                     bus.issue_valid, bus.issue_xu, bus.issue_tag, busy_mem);
        end
        do_reset();
        n_checks++;
        if (bus.issue_valid !== 1'b0 || busy_mem !== 1'b0 || bus.req_gnt !== '0) begin
            n_errors++;
            $display("FAIL reset_idle: got v=%b busy=%b gnt=%b want 0/0/0", bus.issue_valid, busy_mem, bus.req_gnt);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        drive('1, XU_ADDER);
        #1;
        for (int c = 0; c < 5; c++) begin
            exp_g = model_gnt();
            n_checks++;
            if (bus.req_gnt !== exp_g || !$onehot(bus.req_gnt)) begin
                n_errors++;
                $display("FAIL rr_gnt c%0d: got %b want %b one-hot", c, bus.req_gnt, exp_g);
            end
            tick(exp_g);
            n_checks++;
            if (bus.issue_valid !== 1'b1 || bus.issue_tag !== stream_tag_t'(c % N) || bus.issue_xu !== XU_ADDER) begin
                n_errors++;
                $display("FAIL rr_issue c%0d: got v=%b tag=%0d xu=%0d want 1/%0d/%0d",
                         c, bus.issue_valid, bus.issue_tag, bus.issue_xu, c % N, XU_ADDER);
            end
        end
    endtask

    task automatic test_mem_spacing();
        logic want;
        do_reset();
        drive(4'b0011, XU_MEMORY);
        #1;
        for (int c = 0; c < 7; c++) begin
            want  = (c % (MB + 1) == 0);
            exp_g = model_gnt();
            n_checks++;
            if ((|bus.req_gnt) !== want || bus.req_gnt !== exp_g || busy_mem !== !want) begin
                n_errors++;
                $display("FAIL mem_space c%0d: got gnt=%b busy=%b want gnt=%b busy=%b",
                         c, bus.req_gnt, busy_mem, exp_g, !want);
            end
            tick(exp_g);
            n_checks++;
            if (bus.issue_valid !== want || bus.issue_tag !== etag) begin
                n_errors++;
                $display("FAIL mem_issue c%0d: got v=%b tag=%0d want %b/%0d", c, bus.issue_valid, bus.issue_tag, want, etag);
            end
        end
    endtask

    task automatic test_mixed();
        do_reset();
        drive(4'b0011, XU_ADDER);
        bus.req_xu[0] = XU_MEMORY;
        bus.req_xu[1] = XU_LOGICAL;
        #1;
        for (int c = 0; c < 6; c++) begin
            exp_g = model_gnt();
            n_checks++;
            if (bus.req_gnt !== exp_g || ((c == 1 || c == 2) && (bus.req_gnt !== 4'b0010 || busy_mem !== 1'b1))) begin
                n_errors++;
                $display("FAIL mixed_gnt c%0d: got gnt=%b busy=%b want gnt=%b", c, bus.req_gnt, busy_mem, exp_g);
            end
            tick(exp_g);
            n_checks++;
            if (bus.issue_valid !== ev || bus.issue_xu !== exu || bus.issue_tag !== etag) begin
                n_errors++;
                $display("FAIL mixed_issue c%0d: got %b/%0d/%0d want %b/%0d/%0d",
                         c, bus.issue_valid, bus.issue_xu, bus.issue_tag, ev, exu, etag);
            end
        end
    endtask

    task automatic test_jump_squash();
        logic [N-1:0] want;
        do_reset();
        drive(4'b0100, XU_ADDER);
        jump_in = 1'b1; jump_tag = 4'd2;
        #1;
        for (int c = 0; c <= FC + 1; c++) begin
            want  = (c == FC + 1) ? 4'b0100 : 4'b0000;
            exp_g = model_gnt();
            n_checks++;
            if (bus.req_gnt !== want || exp_g !== want) begin
                n_errors++;
                $display("FAIL jump_gnt c%0d: got %b want %b (model %b)", c, bus.req_gnt, want, exp_g);
            end
            tick(exp_g);
            jump_in = 1'b0;
            #1;
        end
        n_checks++;
        if (bus.issue_valid !== 1'b1 || bus.issue_tag !== 4'd2) begin
            n_errors++;
            $display("FAIL jump_issue: got v=%b tag=%0d want 1/2", bus.issue_valid, bus.issue_tag);
        end
    endtask

    task automatic test_stall();
        logic [N-1:0] want;
        do_reset();
        drive('1, XU_ADDER);
        for (int c = 0; c < 7; c++) begin
            stall_in = (c >= 2 && c <= 4);
            #1;
            want  = stall_in ? 4'b0000 : (c == 5) ? 4'b0100 : bus.req_gnt;
            exp_g = model_gnt();
            n_checks++;
            if (bus.req_gnt !== exp_g || bus.req_gnt !== want) begin
                n_errors++;
                $display("FAIL stall_gnt c%0d: got %b want %b", c, bus.req_gnt, exp_g);
            end
            tick(exp_g);
        end
        stall_in = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive('1, XU_MEMORY);
        #1;
        exp_g = model_gnt();
        tick(exp_g);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.issue_valid !== 1'b0 || bus.issue_xu !== XU_BYPASS || bus.issue_tag !== 4'd0 || busy_mem !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid: got v=%b xu=%0d tag=%0d busy=%b want 0/0/0/0",
                     bus.issue_valid, bus.issue_xu, bus.issue_tag, busy_mem);
        end
        @(posedge clk);
        @(negedge clk) reset = 1'b1;
        model_reset();
        #1;
        exp_g = model_gnt();
        n_checks++;
        if (bus.req_gnt !== 4'b0001 || exp_g !== 4'b0001) begin
            n_errors++;
            $display("FAIL reset_first: got %b want 0001", bus.req_gnt);
        end
        tick(exp_g);
        n_checks++;
        if (bus.issue_valid !== 1'b1 || bus.issue_tag !== 4'd0 || bus.issue_xu !== XU_MEMORY) begin
            n_errors++;
            $display("FAIL reset_first_issue: got v=%b tag=%0d want 1/0", bus.issue_valid, bus.issue_tag);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int s = 0; s < N; s++) begin
                bus.req_valid[s] = ($urandom_range(0, 3) != 0);
                bus.req_xu[s]    = xu'($urandom_range(0, 3));
            end
            stall_in = ($urandom_range(0, 9) == 0);
            jump_in  = ($urandom_range(0, 4) == 0);
            jump_tag = stream_tag_t'($urandom_range(0, 7));
            #1;
            exp_g = model_gnt();
            n_checks++;
            if (bus.req_gnt !== exp_g || busy_mem !== model_busy()) begin
                n_errors++;
                $display("FAIL rand_gnt c%0d: got gnt=%b busy=%b want gnt=%b busy=%b",
                         c, bus.req_gnt, busy_mem, exp_g, model_busy());
            end
            tick(exp_g);
            n_checks++;
            if (bus.issue_valid !== ev || bus.issue_xu !== exu || bus.issue_tag !== etag) begin
                n_errors++;
                $display("FAIL rand_issue c%0d: got %b/%0d/%0d want %b/%0d/%0d",
                         c, bus.issue_valid, bus.issue_xu, bus.issue_tag, ev, exu, etag);
            end
        end
        stall_in = 1'b0; jump_in = 1'b0;
    endtask

`ifdef EXEC_SCHED_PERF_EN
    task automatic test_perf();
        do_reset();
        drive('1, XU_ADDER);
        #1;
        for (int c = 0; c < 8; c++) begin
            exp_g = model_gnt();
            tick(exp_g);
        end
        for (int s = 0; s < N; s++) begin
            n_checks++;
            if (grant_cnt[s] !== 32'd2) begin
                n_errors++;
                $display("FAIL perf_grant s%0d: got %0d want 2", s, grant_cnt[s]);
            end
        end
        n_checks++;
        if (blk_cnt !== 32'd0) begin
            n_errors++;
            $display("FAIL perf_blk_rr: got %0d want 0", blk_cnt);
        end
        do_reset();
        drive(4'b0011, XU_MEMORY);
        #1;
        for (int c = 0; c < 7; c++) begin
            exp_g = model_gnt();
            tick(exp_g);
        end
        n_checks++;
        if (blk_cnt !== 32'(m_blk) || m_blk != 4) begin
            n_errors++;
            $display("FAIL perf_blk_mem: got %0d want %0d", blk_cnt, m_blk);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_mem_spacing();
        test_mixed();
        test_jump_squash();
        test_stall();
        test_reset_mid();
        test_random();
`ifdef EXEC_SCHED_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
